mic1_sequencer: RTL and testbench
=================================

Name: mic1_sequencer

Overview:
- Microprogram sequencer for the MIC-1 datapath.
- Reads 36-bit microinstructions from an external control store and drives the ULA select, shifter, C-bus enables, B-bus select and memory strobes.
- Computes the next MPC from NEXT_ADDRESS, JAMN/JAMZ/JMPC, the ULA N/Z outputs and MBR.
- Stalls on memory handshakes.

Parameters:
- START_ADDR, 9'h000, MPC value loaded on reset.
- HALT_ADDR, 9'h1FF, a NEXT_ADDRESS equal to this with JAM=000 halts the sequencer.
- MEM_TIMEOUT, 16, maximum cycles in WAIT_MEM before a timeout halt; valid range 1..255.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cs_addr  out  9  control store address (the MPC)
- cs_en  out  1  control store read enable
- cs_data  in  36  microinstruction; valid on the cycle after cs_en
- N  in  1  ULA negative flag (combinational, from the current ULA result)
- Z  in  1  ULA zero flag
- mbr  in  8  MBR byte, used by JMPC
- ula_select  out  6  ULA function code
- shift  out  2  {SLL8, SRA1}
- c_enable  out  9  C-bus register write enables
- b_select  out  4  B-bus source
- mem_read, mem_write, mem_fetch  out  1 each  memory strobes
- mem_ready  in  1  memory operation complete
- n_flag, z_flag  out  1 each  N/Z registered at the end of each EXEC
- halted  out  1  sequencer stopped
- timeout  out  1  halt was caused by a memory timeout
- illegal  out  1  halt was caused by an illegal ALU code (see Optional Feature)

Behaviour:
- Microinstruction fields:
  - [35:27] NEXT_ADDRESS
  - [26:24] JAM = {JMPC, JAMN, JAMZ}
  - [23:22] shift
  - [21:16] ula_select
  - [15:7] c_enable
  - [6:4] {write, read, fetch}
  - [3:0] b_select
- Reset (async) values:
  - State = FETCH, MPC = START_ADDR, MIR = 0.
  - All strobes and c_enable = 0; ula_select = 6'b010000 (constant 0).
  - n_flag = z_flag = halted = timeout = illegal = 0.
- State machine FETCH -> EXEC -> (WAIT_MEM) -> FETCH; HALT is terminal until reset.
  - FETCH: cs_en = 1, cs_addr = MPC. Next state is EXEC.
  - EXEC:
    - MIR = cs_data, captured at the FETCH->EXEC edge.
    - Datapath outputs are driven from MIR for exactly this one cycle.
    - At the end of EXEC: n_flag <= N, z_flag <= Z, MPC <= next.
  - Next-address computation in EXEC:
    - next = NEXT_ADDRESS.
    - If JAMN & N, set next[8]. If JAMZ & Z, set next[8].
    - If JMPC, next[7:0] = NEXT_ADDRESS[7:0] | mbr.
    - All of these use the live N/Z inputs.
  - EXEC exit:
    - Any memory bit set -> WAIT_MEM.
    - Else NEXT_ADDRESS == HALT_ADDR with JAM == 000 -> HALT.
    - Else -> FETCH.
  - WAIT_MEM:
    - Strobes are 0 and c_enable = 0.
    - A counter counts cycles.
    - mem_ready = 1 -> FETCH, or HALT if the halt condition held.
    - Counter reaches MEM_TIMEOUT without mem_ready -> HALT with timeout = 1.
  - HALT: halted = 1, all outputs at reset values, MPC frozen.
- Outside EXEC: c_enable = 0, strobes = 0, ula_select = 010000, shift = 0, b_select = 0.
- Memory strobes are one-cycle pulses, asserted only in EXEC.
- mem_ready is ignored outside WAIT_MEM. If mem_ready is already high on entry to WAIT_MEM, the exit is taken after exactly one WAIT_MEM cycle.
- Minimum microinstruction period is 2 cycles; a memory microinstruction takes 3 + wait cycles.
- MPC arithmetic is 9-bit with no carry; bit 8 is only ever OR-set.
- Reset asserted in any state aborts immediately, with no strobe glitch beyond the current cycle.

Optional Feature:
- Macro: MIC1_ILLEGAL_ALU_TRAP_EN.
- When defined:
  - In EXEC, if ula_select is not one of the 16 legal codes (011000, 010100, 011010, 101100, 111100, 111101, 111001, 110101, 111111, 110110, 111011, 001100, 011100, 010000, 110001, 110010), then c_enable and all strobes are forced to 0 that cycle.
  - The sequencer goes to HALT with illegal = 1.
- When undefined: codes pass through unchecked and illegal is tied to 0.

Test Plan:
- Reset with START_ADDR = 0; control store[0] = {NEXT_ADDRESS 9'h005, JAM 000, ULA 111100, C 9'h001} -> cs_addr = 0 in cycle 1; ula_select = 111100 and c_enable = 001 in cycle 2; cs_addr = 5 in cycle 3.
- JAMZ with NEXT_ADDRESS 9'h010 and Z = 1 during EXEC -> next MPC = 9'h110, z_flag = 1. Repeat with Z = 0 -> MPC = 9'h010.
- JMPC with NEXT_ADDRESS 9'h100 and mbr = 8'h36 -> next MPC = 9'h136.
- Read microinstruction with mem_ready held low 3 cycles after EXEC -> mem_read pulses for 1 cycle, no FETCH until the mem_ready cycle, total period 6 cycles.
- mem_ready never asserted, MEM_TIMEOUT = 16 -> halted = 1 and timeout = 1 after 16 WAIT_MEM cycles; mid-stall reset clears both asynchronously.
- NEXT_ADDRESS = 9'h1FF with JAM = 000 -> halted = 1 and cs_en stays 0. With MIC1_ILLEGAL_ALU_TRAP_EN defined, ula_select = 000000 -> c_enable = 0 in that EXEC, illegal = 1, halted.

Source files
------------

// File: rtl/mic1_sequencer.sv
// MIC-1 microprogram sequencer: FETCH/EXEC/WAIT_MEM/HALT control with JAM next-address logic.
// Optional illegal-ALU-code trap is enabled by defining MIC1_ILLEGAL_ALU_TRAP_EN.
module mic1_sequencer #(
  parameter logic [8:0]  START_ADDR  = 9'h000,
  parameter logic [8:0]  HALT_ADDR   = 9'h1FF,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic [8:0]  cs_addr,
  output logic        cs_en,
  input  logic [35:0] cs_data,
  input  logic        N,
  input  logic        Z,
  input  logic [7:0]  mbr,
  output logic [5:0]  ula_select,
  output logic [1:0]  shift,
  output logic [8:0]  c_enable,
  output logic [3:0]  b_select,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_fetch,
  input  logic        mem_ready,
  output logic        n_flag,
  output logic        z_flag,
  output logic        halted,
  output logic        timeout,
  output logic        illegal
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;

  localparam logic [7:0] TMO      = 8'(MEM_TIMEOUT);
  localparam logic [5:0] ULA_ZERO = 6'b010000;

  state_t      state_q, state_d;
  logic [8:0]  mpc_q, mpc_d;
  logic [35:0] mir_q, mir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        n_q, n_d, z_q, z_d;
  logic        tmo_q, tmo_d;
  logic        pend_q, pend_d;

  logic [8:0]  mir_na;
  logic [2:0]  mir_jam;
  logic [8:0]  nxt;
  logic        halt_cond;

  assign mir_na    = mir_q[35:27];
  assign mir_jam   = mir_q[26:24];
  assign halt_cond = (mir_na == HALT_ADDR) && (mir_jam == 3'b000);

  // Bit 8 is only ever OR-set; JMPC ORs the MBR byte into the low bits.
  always_comb begin
    nxt = mir_na;
    if ((mir_jam[1] & N) | (mir_jam[0] & Z)) nxt[8] = 1'b1;
    if (mir_jam[2]) nxt[7:0] = mir_na[7:0] | mbr;
  end

`ifdef MIC1_ILLEGAL_ALU_TRAP_EN
  logic ill_q, ill_d;

  function automatic logic alu_legal(input logic [5:0] code);
    case (code)
      6'b011000, 6'b010100, 6'b011010, 6'b101100,
      6'b111100, 6'b111101, 6'b111001, 6'b110101,
      6'b111111, 6'b110110, 6'b111011, 6'b001100,
      6'b011100, 6'b010000, 6'b110001, 6'b110010: alu_legal = 1'b1;
      default:                                     alu_legal = 1'b0;
    endcase
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    mpc_d      = mpc_q;
    mir_d      = mir_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    z_d        = z_q;
    tmo_d      = tmo_q;
    pend_d     = pend_q;
`ifdef MIC1_ILLEGAL_ALU_TRAP_EN
    ill_d      = ill_q;
`endif
    cs_en      = 1'b0;
    ula_select = ULA_ZERO;
    shift      = 2'b00;
    c_enable   = 9'h000;
    b_select   = 4'h0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    mem_fetch  = 1'b0;
    case (state_q)
      S_FETCH: begin
        cs_en   = 1'b1;
        mir_d   = cs_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        shift      = mir_q[23:22];
        ula_select = mir_q[21:16];
        c_enable   = mir_q[15:7];
        mem_write  = mir_q[6];
        mem_read   = mir_q[5];
        mem_fetch  = mir_q[4];
        b_select   = mir_q[3:0];
        n_d        = N;
        z_d        = Z;
        mpc_d      = nxt;
        cnt_d      = 8'd0;
        pend_d     = halt_cond;
        if (|mir_q[6:4])    state_d = S_WAIT;
        else if (halt_cond) state_d = S_HALT;
        else                state_d = S_FETCH;
`ifdef MIC1_ILLEGAL_ALU_TRAP_EN
        if (!alu_legal(mir_q[21:16])) begin
          c_enable  = 9'h000;
          mem_write = 1'b0;
          mem_read  = 1'b0;
          mem_fetch = 1'b0;
          ill_d     = 1'b1;
          state_d   = S_HALT;
        end
`endif
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d = pend_q ? S_HALT : S_FETCH;
        end else if ((cnt_q + 8'd1) == TMO) begin
          state_d = S_HALT;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      mpc_q   <= START_ADDR;
      mir_q   <= 36'h0;
      cnt_q   <= 8'd0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      tmo_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mpc_q   <= mpc_d;
      mir_q   <= mir_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      z_q     <= z_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
    end
  end

`ifdef MIC1_ILLEGAL_ALU_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ill_q <= 1'b0;
    else       ill_q <= ill_d;
  end
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

  assign cs_addr = mpc_q;
  assign n_flag  = n_q;
  assign z_flag  = z_q;
  assign timeout = tmo_q;
  assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_mic1_sequencer.sv
// Directed bench for mic1_sequencer with a combinational control store and negedge sampling.
module tb_mic1_sequencer;

  logic        clock, reset;
  logic [8:0]  cs_addr;
  logic        cs_en;
  logic [35:0] cs_data;
  logic        N, Z;
  logic [7:0]  mbr;
  logic [5:0]  ula_select;
  logic [1:0]  shift;
  logic [8:0]  c_enable;
  logic [3:0]  b_select;
  logic        mem_read, mem_write, mem_fetch, mem_ready;
  logic        n_flag, z_flag, halted, timeout, illegal;

  logic [35:0] rom [0:511];
  int errors = 0;
  int checks = 0;

  mic1_sequencer #(.START_ADDR(9'h000), .HALT_ADDR(9'h1FF), .MEM_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .cs_addr(cs_addr), .cs_en(cs_en), .cs_data(cs_data),
    .N(N), .Z(Z), .mbr(mbr), .ula_select(ula_select), .shift(shift), .c_enable(c_enable),
    .b_select(b_select), .mem_read(mem_read), .mem_write(mem_write), .mem_fetch(mem_fetch),
    .mem_ready(mem_ready), .n_flag(n_flag), .z_flag(z_flag), .halted(halted),
    .timeout(timeout), .illegal(illegal)
  );

  assign cs_data = rom[cs_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [35:0] mi(input logic [8:0] na, input logic [2:0] jam,
                                     input logic [1:0] sh, input logic [5:0] ula,
                                     input logic [8:0] c, input logic [2:0] mem,
                                     input logic [3:0] b);
    return {na, jam, sh, ula, c, mem, b};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; N = 1'b0; Z = 1'b0; mbr = 8'h00; mem_ready = 1'b0;
    for (int i = 0; i < 512; i++) rom[i] = 36'h0;
    rom[9'h000] = mi(9'h005, 3'b000, 2'b10, 6'b111100, 9'h001, 3'b000, 4'h4);
    rom[9'h005] = mi(9'h010, 3'b001, 2'b00, 6'b010100, 9'h000, 3'b000, 4'h0);
    rom[9'h110] = mi(9'h010, 3'b001, 2'b00, 6'b010100, 9'h000, 3'b000, 4'h0);
    rom[9'h010] = mi(9'h100, 3'b100, 2'b00, 6'b010100, 9'h000, 3'b000, 4'h0);
    rom[9'h136] = mi(9'h020, 3'b000, 2'b00, 6'b010000, 9'h000, 3'b010, 4'h1);
    rom[9'h020] = mi(9'h1FF, 3'b000, 2'b00, 6'b010000, 9'h000, 3'b000, 4'h0);

    repeat (2) @(negedge clock);
    chk("rst_ula", ula_select, 6'b010000);
    chk("rst_cen", c_enable, 9'h000);
    chk("rst_strobes", {mem_write, mem_read, mem_fetch}, 3'b000);
    chk("rst_flags", {n_flag, z_flag, halted, timeout, illegal}, 5'b00000);
    reset = 1'b0;
    chk("c1_cs_addr", cs_addr, 9'h000);
    chk("c1_cs_en", cs_en, 1'b1);

    @(negedge clock);
    chk("c2_ula", ula_select, 6'b111100);
    chk("c2_cen", c_enable, 9'h001);
    chk("c2_shift", shift, 2'b10);
    chk("c2_bsel", b_select, 4'h4);
    chk("c2_cs_en", cs_en, 1'b0);

    @(negedge clock);
    chk("c3_cs_addr", cs_addr, 9'h005);
    chk("c3_ula_idle", ula_select, 6'b010000);
    chk("c3_cen_idle", c_enable, 9'h000);

    @(negedge clock);
    Z = 1'b1;
    @(negedge clock);
    chk("jamz1_mpc", cs_addr, 9'h110);
    chk("jamz1_zflag", z_flag, 1'b1);
    Z = 1'b0;
    @(negedge clock);
    N = 1'b1;
    @(negedge clock);
    chk("jamz0_mpc", cs_addr, 9'h010);
    chk("jamz0_flags", {n_flag, z_flag}, 2'b10);
    N = 1'b0;
    mbr = 8'h36;
    @(negedge clock);
    @(negedge clock);
    chk("jmpc_mpc", cs_addr, 9'h136);
    mbr = 8'h00;

    @(negedge clock);
    chk("rd_pulse", {mem_write, mem_read, mem_fetch}, 3'b010);
    chk("rd_bsel", b_select, 4'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rd_wait_strobes", {mem_write, mem_read, mem_fetch, cs_en}, 4'b0000);
    end
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    chk("rd_refetch_en", cs_en, 1'b1);
    chk("rd_refetch_addr", cs_addr, 9'h020);

    @(negedge clock);
    @(negedge clock);
    chk("halt_halted", halted, 1'b1);
    chk("halt_cs_en", cs_en, 1'b0);
    chk("halt_timeout", timeout, 1'b0);
    repeat (3) @(negedge clock);
    chk("halt_stays", {halted, cs_en, cs_addr}, {1'b1, 1'b0, 9'h1FF});

    rom[9'h000] = mi(9'h030, 3'b000, 2'b00, 6'b010000, 9'h0FF, 3'b100, 4'h0);
    reset = 1'b1;
    #1;
    chk("async_rst_halt", {halted, cs_en, cs_addr}, {1'b0, 1'b1, 9'h000});
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("wr_pulse", {mem_write, mem_read, mem_fetch}, 3'b100);
    chk("wr_cen", c_enable, 9'h0FF);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk("tmo_waiting", {halted, mem_write, cs_en}, 3'b000);
    end
    @(negedge clock);
    chk("tmo_halt", {halted, timeout}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("tmo_async_clear", {halted, timeout}, 2'b00);
    @(negedge clock);
    reset = 1'b0;

    @(negedge clock);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midwait_rst", {cs_en, mem_write, halted, cs_addr}, {1'b1, 1'b0, 1'b0, 9'h000});

    rom[9'h000] = mi(9'h040, 3'b000, 2'b00, 6'b000000, 9'h1AA, 3'b010, 4'h3);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
`ifdef MIC1_ILLEGAL_ALU_TRAP_EN
    chk("ill_cen", c_enable, 9'h000);
    chk("ill_strobes", {mem_write, mem_read, mem_fetch}, 3'b000);
    @(negedge clock);
    chk("ill_halt", {halted, illegal, timeout}, 3'b110);
`else
    chk("noill_ula", ula_select, 6'b000000);
    chk("noill_cen", c_enable, 9'h1AA);
    chk("noill_rd", mem_read, 1'b1);
    @(negedge clock);
    chk("noill_flag", {halted, illegal}, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
